uart_rx_cmd_parser: RTL



---
 rtl/uart_rx_cmd_parser_if.sv | 29 ++
 rtl/uart_rx_cmd_parser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_parser_if.sv
// Command handshake bundle between the UART frame parser and the sensor controller.
//   cmd_valid : command available (parser -> consumer)
//   cmd_ready : consumer accepts the held command (consumer -> parser)
//   cmd       : command byte
//   addr      : address byte
//   data      : {data_hi, data_lo}
interface uart_rx_cmd_parser_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd;
   logic [7:0]  addr;
   logic [15:0] data;

   modport master (
      output cmd_valid,
      output cmd,
      output addr,
      output data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd,
      input  addr,
      input  data,
      output cmd_ready
   );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// UART command frame parser.
// Assembles 6-byte host frames {sync, cmd, addr, data_hi, data_lo, checksum}
// from the UART receiver's byte strobe, validates the XOR checksum and hands
// good commands to the sensor controller over a valid/ready bus.
//
// Ports:
//   i_CLK      : system clock
//   i_RST      : synchronous active-high reset
//   i_Rx_DV    : one-cycle byte strobe from the UART receiver
//   i_Rx_Byte  : received byte, valid with i_Rx_DV
//   cmd_bus    : command handshake (master side: cmd_valid/cmd/addr/data out, cmd_ready in)
//   o_Chk_Err  : 1-cycle pulse, checksum mismatch
//   o_Overrun  : 1-cycle pulse, good frame dropped because a command was still pending
//   o_Timeout  : 1-cycle pulse, partial frame abandoned after an inter-byte timeout
//   o_Busy     : high while a frame is being assembled
//
// Optional feature: define UART_RX_CMD_TIMEOUT_EN to enable the inter-byte
// timeout. Without it o_Timeout stays 0 and partial frames wait indefinitely.
module uart_rx_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
   parameter int unsigned TIMEOUT_CLKS = 10000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                        i_CLK,
   input  logic                        i_RST,
   input  logic                        i_Rx_DV,
   input  logic [7:0]                  i_Rx_Byte,
   uart_rx_cmd_parser_if.master        cmd_bus,
   output logic                        o_Chk_Err,
   output logic                        o_Overrun,
   output logic                        o_Timeout,
   output logic                        o_Busy
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DATA_W = 16;

   localparam logic [2:0] S_SYNC = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DH   = 3'd3;
   localparam logic [2:0] S_DL   = 3'd4;
   localparam logic [2:0] S_CHK  = 3'd5;

   logic [2:0]        state_q,   state_nxt;
   logic [BYTE_W-1:0] cmd_sh_q,  cmd_sh_nxt;
   logic [BYTE_W-1:0] addr_sh_q, addr_sh_nxt;
   logic [BYTE_W-1:0] dh_sh_q,   dh_sh_nxt;
   logic [BYTE_W-1:0] dl_sh_q,   dl_sh_nxt;
   logic [BYTE_W-1:0] xor_q,     xor_nxt;
   logic              valid_q,   valid_nxt;
   logic [BYTE_W-1:0] cmd_q,     cmd_nxt;
   logic [BYTE_W-1:0] addr_q,    addr_nxt;
   logic [DATA_W-1:0] data_q,    data_nxt;
   logic              chk_err_q, chk_err_nxt;
   logic              overrun_q, overrun_nxt;
   logic              timeout_q, timeout_nxt;
   logic              busy_q,    busy_nxt;
   logic              good_c;

`ifdef UART_RX_CMD_TIMEOUT_EN
   logic [CNT_W-1:0]  cnt_q,     cnt_nxt;
`else
   // Keeps the timeout configuration referenced when the feature is compiled out.
   logic unused_cfg;
   assign unused_cfg = ^{32'(TIMEOUT_CLKS), 32'(CNT_W)};
`endif

   // State and datapath registers.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= S_SYNC;
         cmd_sh_q  <= '0;
         addr_sh_q <= '0;
         dh_sh_q   <= '0;
         dl_sh_q   <= '0;
         xor_q     <= '0;
         valid_q   <= 1'b0;
         cmd_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         chk_err_q <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_CMD_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_nxt;
         cmd_sh_q  <= cmd_sh_nxt;
         addr_sh_q <= addr_sh_nxt;
         dh_sh_q   <= dh_sh_nxt;
         dl_sh_q   <= dl_sh_nxt;
         xor_q     <= xor_nxt;
         valid_q   <= valid_nxt;
         cmd_q     <= cmd_nxt;
         addr_q    <= addr_nxt;
         data_q    <= data_nxt;
         chk_err_q <= chk_err_nxt;
         overrun_q <= overrun_nxt;
         timeout_q <= timeout_nxt;
         busy_q    <= busy_nxt;
`ifdef UART_RX_CMD_TIMEOUT_EN
         cnt_q     <= cnt_nxt;
`endif
      end
   end

   // Next-state, frame assembly and handshake logic.
   always_comb begin
      state_nxt   = state_q;
      cmd_sh_nxt  = cmd_sh_q;
      addr_sh_nxt = addr_sh_q;
      dh_sh_nxt   = dh_sh_q;
      dl_sh_nxt   = dl_sh_q;
      xor_nxt     = xor_q;
      valid_nxt   = valid_q;
      cmd_nxt     = cmd_q;
      addr_nxt    = addr_q;
      data_nxt    = data_q;
      chk_err_nxt = 1'b0;
      overrun_nxt = 1'b0;
      timeout_nxt = 1'b0;
      good_c      = 1'b0;
`ifdef UART_RX_CMD_TIMEOUT_EN
      cnt_nxt     = cnt_q + CNT_W'(1);
`endif

      // Held command retires once sampled with ready; a same-cycle load overrides below.
      if (valid_q && cmd_bus.cmd_ready) begin
         valid_nxt = 1'b0;
      end

      if (i_Rx_DV) begin
         case (state_q)
            S_SYNC: begin
               if (i_Rx_Byte == SYNC_BYTE) begin
                  state_nxt = S_CMD;
                  xor_nxt   = '0;
               end
            end
            S_CMD: begin
               cmd_sh_nxt = i_Rx_Byte;
               xor_nxt    = xor_q ^ i_Rx_Byte;
               state_nxt  = S_ADDR;
            end
            S_ADDR: begin
               addr_sh_nxt = i_Rx_Byte;
               xor_nxt     = xor_q ^ i_Rx_Byte;
               state_nxt   = S_DH;
            end
            S_DH: begin
               dh_sh_nxt = i_Rx_Byte;
               xor_nxt   = xor_q ^ i_Rx_Byte;
               state_nxt = S_DL;
            end
            S_DL: begin
               dl_sh_nxt = i_Rx_Byte;
               xor_nxt   = xor_q ^ i_Rx_Byte;
               state_nxt = S_CHK;
            end
            S_CHK: begin
               state_nxt = S_SYNC;
               if (i_Rx_Byte == xor_q) begin
                  good_c = 1'b1;
               end else begin
                  chk_err_nxt = 1'b1;
               end
            end
            default: state_nxt = S_SYNC;
         endcase
      end else if (state_q > S_CHK) begin
         // Recover from an unused encoding even without byte traffic.
         state_nxt = S_SYNC;
      end

      // Deliver a good frame if the output slot is free or being freed this cycle.
      if (good_c) begin
         if (!valid_q || cmd_bus.cmd_ready) begin
            valid_nxt = 1'b1;
            cmd_nxt   = cmd_sh_q;
            addr_nxt  = addr_sh_q;
            data_nxt  = {dh_sh_q, dl_sh_q};
         end else begin
            overrun_nxt = 1'b1;
         end
      end

`ifdef UART_RX_CMD_TIMEOUT_EN
      // Inter-byte watchdog; a byte on the terminal cycle wins over the timeout.
      if (state_q == S_SYNC || i_Rx_DV) begin
         cnt_nxt = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
         cnt_nxt     = '0;
         state_nxt   = S_SYNC;
         timeout_nxt = 1'b1;
      end
`endif

      busy_nxt = (state_nxt != S_SYNC);
   end

   assign cmd_bus.cmd_valid = valid_q;
   assign cmd_bus.cmd       = cmd_q;
   assign cmd_bus.addr      = addr_q;
   assign cmd_bus.data      = data_q;
   assign o_Chk_Err         = chk_err_q;
   assign o_Overrun         = overrun_q;
   assign o_Timeout         = timeout_q;
   assign o_Busy            = busy_q;

endmodule
